// File: rtl/roll_sequencer_if.sv
// roll_sequencer_if
//   Bundles the start/random inputs and the LFSR/display outputs of the
//   roll sequencer.
//   Modports:
//     slave  - the sequencer. It takes i_start and i_rand and drives the rest.
//     master - the surrounding logic. It drives i_start and i_rand.
//   Signals:
//     i_start  single-cycle debounced start pulse
//     i_rand   low nibble of the current LFSR state
//     o_seed   seed presented to the LFSR load port
//     o_load   one-cycle LFSR load strobe
//     o_step   one-cycle LFSR advance strobe
//     o_value  displayed random value
//     o_busy   a roll is in progress (LOAD or RUN)
//     o_done   one-cycle pulse when a roll completes
interface roll_sequencer_if;
   logic        i_start;
   logic [3:0]  i_rand;
   logic [15:0] o_seed;
   logic        o_load;
   logic        o_step;
   logic [3:0]  o_value;
   logic        o_busy;
   logic        o_done;

   modport master (
      output i_start, i_rand,
      input  o_seed, o_load, o_step, o_value, o_busy, o_done
   );

   modport slave (
      input  i_start, i_rand,
      output o_seed, o_load, o_step, o_value, o_busy, o_done
   );
endinterface

// File: rtl/roll_sequencer.sv
// roll_sequencer
//   Sequences the 16-bit LFSR datapath for the dice display.
//   - A free-running seed counter is loaded into the LFSR when a roll starts.
//   - The LFSR is then stepped on a decelerating schedule.
//   - A 4-bit display value is latched at every step.
//   - A done pulse is produced at the end of the roll.
//   Ports:
//     i_clk  clock
//     i_rst  asynchronous reset, active high
//     bus    roll_sequencer_if.slave (start/rand in; seed/load/step/value/busy/done out)
//   Parameters:
//     BASE_GAP    cycles between steps in the flat phase
//     GAP_INC     extra cycles added per step after the flat phase
//     FLAT_STEPS  number of initial steps that use BASE_GAP
//     STEPS       steps per roll (>= 1)
//   Optional feature macro: ROLL_NO_REPEAT_EN
//     When defined, a sampled value equal to the value on display is bumped by
//     one (mod 16), so consecutive displayed values always differ.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for i_start
//   LOAD  | one cycle, o_load high, LFSR takes o_seed
//   RUN   | count gaps, strobe o_step and latch the value at each gap end
module roll_sequencer #(
   parameter int unsigned BASE_GAP   = 5000000,
   parameter int unsigned GAP_INC    = 2000000,
   parameter int unsigned FLAT_STEPS = 6,
   parameter int unsigned STEPS      = 14
) (
   input  logic             i_clk,
   input  logic             i_rst,
   roll_sequencer_if.slave  bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   localparam logic [31:0] LAST_IDX  = 32'(STEPS - 1);
   localparam logic [31:0] FLAT_LIM  = 32'(FLAT_STEPS);
   localparam logic [31:0] INC_W     = 32'(GAP_INC);
   // With no flat phase the very first gap already carries one increment.
   localparam logic [31:0] FIRST_GAP = (FLAT_STEPS == 0) ? 32'(BASE_GAP + GAP_INC)
                                                         : 32'(BASE_GAP);

   logic [1:0]  state;
   logic [15:0] seed;
   logic [31:0] gap_cnt;
   logic [31:0] gap_cur;
   logic [31:0] step_idx;
   logic [3:0]  value;
   logic        done;

   logic        step_hit;
   logic        fire;
   logic        last_step;
   logic [31:0] gap_next;
   logic [3:0]  latch_val;

   // Seed skips zero so the LFSR is never loaded with its lock-up state.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         seed <= 16'h0001;
      end else if (seed == 16'hFFFF) begin
         seed <= 16'h0001;
      end else begin
         seed <= seed + 16'h0001;
      end
   end

   assign step_hit  = (state == ST_RUN) && (gap_cnt == gap_cur);
   // A restart request in the same cycle as a step end suppresses the step.
   assign fire      = step_hit && !bus.i_start;
   assign last_step = (step_idx == LAST_IDX);

   // The gap grows by GAP_INC for every step at or beyond the flat phase.
   // Adding incrementally avoids a 32-bit multiplier.
   assign gap_next  = ((step_idx + 32'd1) < FLAT_LIM) ? gap_cur : gap_cur + INC_W;

`ifdef ROLL_NO_REPEAT_EN
   assign latch_val = (bus.i_rand == value) ? bus.i_rand + 4'd1 : bus.i_rand;
`else
   assign latch_val = bus.i_rand;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= ST_IDLE;
         gap_cnt  <= 32'd0;
         gap_cur  <= 32'd0;
         step_idx <= 32'd0;
         value    <= 4'd0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.i_start) begin
                  state    <= ST_LOAD;
                  step_idx <= 32'd0;
                  gap_cnt  <= 32'd0;
               end
            end
            ST_LOAD: begin
               state    <= ST_RUN;
               step_idx <= 32'd0;
               gap_cnt  <= 32'd1;
               gap_cur  <= FIRST_GAP;
            end
            ST_RUN: begin
               if (bus.i_start) begin
                  state    <= ST_LOAD;
                  step_idx <= 32'd0;
                  gap_cnt  <= 32'd0;
               end else if (step_hit) begin
                  value    <= latch_val;
                  step_idx <= step_idx + 32'd1;
                  gap_cnt  <= 32'd1;
                  gap_cur  <= gap_next;
                  if (last_step) begin
                     state <= ST_IDLE;
                     done  <= 1'b1;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 32'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.o_seed  = seed;
   assign bus.o_load  = (state == ST_LOAD);
   assign bus.o_busy  = (state == ST_LOAD) || (state == ST_RUN);
   assign bus.o_step  = fire;
   assign bus.o_value = value;
   assign bus.o_done  = done;

endmodule

// File: tb/tb_roll_sequencer.sv
// tb_roll_sequencer
//   Self-checking bench for roll_sequencer.
//   Configuration: BASE_GAP=4, GAP_INC=2, FLAT_STEPS=2, STEPS=4.
//   Gaps are therefore 4, 4, 6 and 8 cycles.
//   A schedule-based reference model predicts every output on every cycle.
//   Directed tables and sequences cover the corner cases.
module tb_roll_sequencer;
   localparam int unsigned BASE_GAP   = 4;
   localparam int unsigned GAP_INC    = 2;
   localparam int unsigned FLAT_STEPS = 2;
   localparam int unsigned STEPS      = 4;

`ifdef ROLL_NO_REPEAT_EN
   localparam bit NO_REP = 1'b1;
`else
   localparam bit NO_REP = 1'b0;
`endif

   logic i_clk = 1'b0;
   logic i_rst;

   roll_sequencer_if bus_if ();

   roll_sequencer #(
      .BASE_GAP   (BASE_GAP),
      .GAP_INC    (GAP_INC),
      .FLAT_STEPS (FLAT_STEPS),
      .STEPS      (STEPS)
   ) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus_if.slave)
   );

   always #5 i_clk = ~i_clk;

   int checks   = 0;
   int failures = 0;

   // Reference model state. Each step is an absolute cycle offset from the
   // LOAD cycle of the current roll.
   int          cum [STEPS];
   longint      cyc;
   longint      load_t;
   longint      done_t;
   bit          live;
   int          k_next;
   logic [3:0]  m_value;
   int          n_seed;

   logic [15:0] smp_seed;
   logic        smp_load, smp_step, smp_busy, smp_done;
   logic [3:0]  smp_value;

   typedef struct {
      int   rel;
      logic load;
      logic step;
      logic busy;
      logic done;
   } ev_t;

   ev_t full_tab [10];

   function automatic logic [3:0] apply_rule(logic [3:0] r, logic [3:0] cur);
      logic [3:0] bumped;
      bumped = r + 4'd1;
      return (NO_REP && (r == cur)) ? bumped : r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc - 1, act, exp);
      end
   endtask

   // One clock cycle.
   // - Drive the inputs, then sample and compare the outputs at the negedge.
   // - Advance the model at the posedge.
   task automatic run_cycle(input logic start, input logic [3:0] rnd, input logic rst);
      logic        e_load, e_step, e_busy, e_done;
      logic [15:0] e_seed;
      logic [3:0]  e_value;
      i_rst          = rst;
      bus_if.i_start = start;
      bus_if.i_rand  = rnd;
      @(negedge i_clk);
      smp_seed  = bus_if.o_seed;
      smp_load  = bus_if.o_load;
      smp_step  = bus_if.o_step;
      smp_busy  = bus_if.o_busy;
      smp_done  = bus_if.o_done;
      smp_value = bus_if.o_value;
      if (rst) begin
         e_load = 1'b0; e_step = 1'b0; e_busy = 1'b0; e_done = 1'b0;
         e_seed = 16'h0001; e_value = 4'd0;
      end else begin
         e_load  = live && (cyc == load_t);
         e_busy  = live;
         e_step  = live && (k_next < int'(STEPS)) && ((cyc - load_t) == longint'(cum[k_next])) && !start;
         e_done  = (cyc == done_t);
         e_seed  = 16'((n_seed % 65535) + 1);
         e_value = m_value;
      end
      cyc++;
      check("seed",  32'(smp_seed),  32'(e_seed));
      check("load",  32'(smp_load),  32'(e_load));
      check("step",  32'(smp_step),  32'(e_step));
      check("busy",  32'(smp_busy),  32'(e_busy));
      check("done",  32'(smp_done),  32'(e_done));
      check("value", 32'(smp_value), 32'(e_value));
      @(posedge i_clk);
      if (rst) begin
         live    = 1'b0;
         m_value = 4'd0;
         n_seed  = 0;
         load_t  = -1;
         done_t  = -1;
         k_next  = 0;
      end else begin
         n_seed++;
         if (e_step) begin
            m_value = apply_rule(rnd, m_value);
            k_next++;
            if (k_next == int'(STEPS)) begin
               live   = 1'b0;
               done_t = cyc;
            end
         end
         if (start && !e_load) begin
            live   = 1'b1;
            load_t = cyc;
            k_next = 0;
         end
      end
      #1;
   endtask

   // Run idle cycles until the cycle with index 'target' has been sampled.
   task automatic advance_to(input longint target, input logic [3:0] rnd);
      while (cyc <= target) run_cycle(1'b0, rnd, 1'b0);
   endtask

   // Pulse start. Returns the index of the LOAD cycle.
   task automatic start_roll(input logic [3:0] rnd, output longint t);
      run_cycle(1'b1, rnd, 1'b0);
      t = cyc;
   endtask

   task automatic do_reset();
      run_cycle(1'b0, 4'd0, 1'b1);
      run_cycle(1'b0, 4'd0, 1'b1);
   endtask

   initial begin
      longint t, t2;
      int acc;
      logic [3:0] v_keep;

      acc = 0;
      for (int k = 0; k < int'(STEPS); k++) begin
         if (k < int'(FLAT_STEPS)) acc += int'(BASE_GAP);
         else acc += int'(BASE_GAP) + (k - int'(FLAT_STEPS) + 1) * int'(GAP_INC);
         cum[k] = acc;
      end

      full_tab[0] = '{0,  1'b1, 1'b0, 1'b1, 1'b0};
      full_tab[1] = '{3,  1'b0, 1'b0, 1'b1, 1'b0};
      full_tab[2] = '{4,  1'b0, 1'b1, 1'b1, 1'b0};
      full_tab[3] = '{5,  1'b0, 1'b0, 1'b1, 1'b0};
      full_tab[4] = '{8,  1'b0, 1'b1, 1'b1, 1'b0};
      full_tab[5] = '{14, 1'b0, 1'b1, 1'b1, 1'b0};
      full_tab[6] = '{21, 1'b0, 1'b0, 1'b1, 1'b0};
      full_tab[7] = '{22, 1'b0, 1'b1, 1'b1, 1'b0};
      full_tab[8] = '{23, 1'b0, 1'b0, 1'b0, 1'b1};
      full_tab[9] = '{24, 1'b0, 1'b0, 1'b0, 1'b0};

      cyc = 0; live = 1'b0; load_t = -1; done_t = -1; k_next = 0;
      m_value = 4'd0; n_seed = 0;

      do_reset();
      check("rst_seed",  32'(smp_seed),  32'h0001);
      check("rst_value", 32'(smp_value), 32'h0);
      run_cycle(1'b0, 4'd0, 1'b0);
      check("seed_after_rst0", 32'(smp_seed), 32'h0001);
      run_cycle(1'b0, 4'd0, 1'b0);
      check("seed_after_rst1", 32'(smp_seed), 32'h0002);
      run_cycle(1'b0, 4'd0, 1'b0);
      check("seed_after_rst2", 32'(smp_seed), 32'h0003);

      // Full roll: schedule from the event table.
      start_roll(4'd3, t);
      for (int i = 0; i < 10; i++) begin
         advance_to(t + longint'(full_tab[i].rel), 4'(i + 7));
         check($sformatf("tab_load@%0d", full_tab[i].rel), 32'(smp_load), 32'(full_tab[i].load));
         check($sformatf("tab_step@%0d", full_tab[i].rel), 32'(smp_step), 32'(full_tab[i].step));
         check($sformatf("tab_busy@%0d", full_tab[i].rel), 32'(smp_busy), 32'(full_tab[i].busy));
         check($sformatf("tab_done@%0d", full_tab[i].rel), 32'(smp_done), 32'(full_tab[i].done));
      end

      // Restart mid-roll.
      start_roll(4'd2, t);
      advance_to(t + 9, 4'd9);
      v_keep = m_value;
      run_cycle(1'b1, 4'd9, 1'b0);
      advance_to(t + 11, 4'd9);
      check("restart_load", 32'(smp_load), 32'd1);
      advance_to(t + 14, 4'd9);
      check("restart_keep", 32'(smp_value), 32'(v_keep));
      advance_to(t + 15, 4'd4);
      check("restart_step", 32'(smp_step), 32'd1);
      advance_to(t + 40, 4'd4);

      // Start coinciding with a step end.
      start_roll(4'd1, t);
      advance_to(t + 7, 4'd1);
      run_cycle(1'b1, 4'd1, 1'b0);
      check("startstep_nostep", 32'(smp_step), 32'd0);
      advance_to(t + 9, 4'd1);
      check("startstep_load", 32'(smp_load), 32'd1);
      t2 = t + 9;
      advance_to(t2 + 24, 4'd1);

      // Start in the done cycle is accepted.
      start_roll(4'd0, t);
      advance_to(t + 23, 4'd0);
      check("done_pulse", 32'(smp_done), 32'd1);
      run_cycle(1'b1, 4'd0, 1'b0);
      check("done_start_busy", 32'(smp_busy), 32'd0);
      run_cycle(1'b0, 4'd0, 1'b0);
      check("done_start_load", 32'(smp_load), 32'd1);
      t = cyc - 1;

      // Mid-roll reset.
      advance_to(t + 6, 4'd0);
      run_cycle(1'b0, 4'd0, 1'b1);
      check("midrst_busy", 32'(smp_busy), 32'd0);
      check("midrst_seed", 32'(smp_seed), 32'h0001);
      advance_to(cyc + 30, 4'd0);
      check("midrst_nodone", 32'(smp_done), 32'd0);

      // No-repeat rule, value 5 against sampled 5.
      do_reset();
      start_roll(4'd5, t);
      advance_to(t + 9, 4'd5);
      check("norep_5", 32'(smp_value), NO_REP ? 32'd6 : 32'd5);
      advance_to(t + 30, 4'd5);

      // No-repeat rule, value F against sampled F.
      do_reset();
      start_roll(4'hF, t);
      advance_to(t + 9, 4'hF);
      check("norep_F", 32'(smp_value), NO_REP ? 32'd0 : 32'hF);
      advance_to(t + 30, 4'hF);

      // Seed wrap.
      do_reset();
      for (int i = 0; i < 65535; i++) run_cycle(1'b0, 4'd0, 1'b0);
      check("seed_ffff", 32'(smp_seed), 32'hFFFF);
      run_cycle(1'b1, 4'd0, 1'b0);
      check("seed_wrap", 32'(smp_seed), 32'h0001);
      run_cycle(1'b0, 4'd0, 1'b0);
      check("wrap_load", 32'(smp_load), 32'd1);
      check("wrap_seed_nonzero", 32'(smp_seed != 16'h0000), 32'd1);
      advance_to(cyc + 30, 4'd0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         run_cycle(($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
                   4'($urandom_range(0, 15)),
                   ($urandom_range(0, 699) == 0) ? 1'b1 : 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
